// File: rtl/ahb_test_mailbox_if.sv
// AHB-Lite write-snoop bus plus the character stream handshake
// for the test mailbox.
interface ahb_test_mailbox_if;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hreadyi;
    logic        hsel;
    logic        msg_valid;
    logic [7:0]  msg_data;
    logic        msg_ready;

    modport master (
        output haddr, htrans, hwrite, hsize,
        output hwdata, hreadyi, hsel, msg_ready,
        input  msg_valid, msg_data
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize,
        input  hwdata, hreadyi, hsel, msg_ready,
        output msg_valid, msg_data
    );
endinterface

// File: rtl/ahb_test_mailbox.sv
// Passive AHB-Lite write snooper driving test flags and a char FIFO.
// Define MBOX_DISPLAY_EN for simulation console echo of the mailbox.
module ahb_test_mailbox #(
    parameter logic [19:0] BASE_ADDR  = 20'h9_0000,
    parameter int          N_CH       = 4,
    parameter int          FIFO_DEPTH = 16,
    parameter int          LVL_W      = 5
) (
    input  logic             hclk,
    input  logic             hresetn,
    ahb_test_mailbox_if.slave bus,
    output logic [N_CH-1:0]  test_start,
    output logic             test_done,
    output logic [7:0]       test_code,
    output logic [LVL_W-1:0] fifo_level,
    output logic [7:0]       ovf_cnt
);

    localparam int AW = LVL_W - 1;

    logic       pend;
    logic [1:0] p_off;
    logic [1:0] p_lane;
    logic [2:0] p_size;

    logic hit, commit, size_ok;
    logic push, pop, accept, drop;
    logic [7:0] chr;

    logic [LVL_W-1:0] wptr, rptr;
    logic [7:0]       mem [FIFO_DEPTH];

    logic unused_ok;
    assign unused_ok = ^{bus.haddr[31:20], bus.htrans[0]};

    assign hit = bus.hsel & bus.hwrite & bus.htrans[1]
               & bus.hreadyi
               & (bus.haddr[19:4] == BASE_ADDR[19:4]);
    assign commit  = pend & bus.hreadyi;
    assign size_ok = (p_size <= 3'd2);
    assign push    = commit & size_ok & (p_off == 2'd2);

    assign fifo_level    = wptr - rptr;
    assign bus.msg_valid = (wptr != rptr);
    assign bus.msg_data  = mem[rptr[AW-1:0]];

    // Level top bit set means exactly FIFO_DEPTH entries held
    assign pop    = bus.msg_valid & bus.msg_ready;
    assign accept = push & (~fifo_level[AW] | pop);
    assign drop   = push & ~accept;

    always_comb begin
        chr = bus.hwdata[7:0];
        unique case (1'b1)
            (p_size == 3'd0): chr = bus.hwdata[8*p_lane +: 8];
            (p_size == 3'd1):
                chr = p_lane[1] ? bus.hwdata[23:16]
                                : bus.hwdata[7:0];
            default: ;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            pend       <= 1'b0;
            p_off      <= '0;
            p_lane     <= '0;
            p_size     <= '0;
            test_start <= '0;
            test_done  <= 1'b0;
            test_code  <= '0;
        end else begin
            // Wait states hold the pending write; hit needs hreadyi
            if (bus.hreadyi) pend <= hit;
            if (hit) begin
                p_off  <= bus.haddr[3:2];
                p_lane <= bus.haddr[1:0];
                p_size <= bus.hsize;
            end
            if (commit && size_ok) begin
                unique case (1'b1)
                    (p_off == 2'd0): begin
                        for (int i = 0; i < N_CH; i++)
                            if (bus.hwdata == 32'(i + 1))
                                test_start[i] <= 1'b1;
                    end
                    (p_off == 2'd1):
                        test_start <= test_start
                                    & ~bus.hwdata[N_CH-1:0];
                    (p_off == 2'd3): begin
                        test_done <= 1'b1;
                        test_code <= bus.hwdata[7:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wptr    <= '0;
            rptr    <= '0;
            ovf_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (accept) begin
                mem[wptr[AW-1:0]] <= chr;
                wptr <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            if (drop && ovf_cnt != 8'hFF)
                ovf_cnt <= ovf_cnt + 8'd1;
        end
    end

`ifdef MBOX_DISPLAY_EN
    always @(posedge hclk) begin
        if (hresetn) begin
            if (pop) $write("%c", bus.msg_data);
            if (commit && size_ok && p_off == 2'd3)
                $display("MBOX DONE code=%02h ovf=%0d",
                         bus.hwdata[7:0], ovf_cnt);
            if (drop) $display("MBOX OVF");
        end
    end
`else
`endif

endmodule

// File: tb/tb_ahb_test_mailbox.sv
// Bench for ahb_test_mailbox: vector table, corner sequences and
// randomized writes against a transaction-level mailbox model.
module tb_ahb_test_mailbox;

    localparam logic [31:0] BASE  = 32'h0009_0000;
    localparam int          DEPTH = 16;

    logic hclk = 1'b0;
    logic hresetn = 1'b0;
    always #5 hclk = ~hclk;

    ahb_test_mailbox_if bus();

    logic [3:0] test_start;
    logic       test_done;
    logic [7:0] test_code;
    logic [4:0] fifo_level;
    logic [7:0] ovf_cnt;

    ahb_test_mailbox #(
        .BASE_ADDR (20'h9_0000),
        .N_CH      (4),
        .FIFO_DEPTH(DEPTH),
        .LVL_W     (5)
    ) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .bus       (bus.slave),
        .test_start(test_start),
        .test_done (test_done),
        .test_code (test_code),
        .fifo_level(fifo_level),
        .ovf_cnt   (ovf_cnt)
    );

    // Reference model: flags, done/code, byte queue, drop count
    logic [3:0] m_start;
    logic       m_done;
    logic [7:0] m_code;
    logic [7:0] q[$];
    int         m_ovf;

    logic        c_en;
    logic [31:0] c_addr, c_data;
    logic [2:0]  c_size;
    bit          rand_rdy;

    int vecs, errs;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  size;
        bit          sel;
        logic [3:0]  es;
        bit          ed;
        logic [7:0]  ec;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_start = '0;
        m_done  = 1'b0;
        m_code  = '0;
        m_ovf   = 0;
        q.delete();
    endtask

    task automatic check_all();
        chk("test_start", 32'(test_start), 32'(m_start));
        chk("test_done", 32'(test_done), 32'(m_done));
        chk("test_code", 32'(test_code), 32'(m_code));
        chk("fifo_level", 32'(fifo_level), q.size());
        chk("ovf_cnt", 32'(ovf_cnt), m_ovf);
        chk("msg_valid", 32'(bus.msg_valid), 32'(q.size() != 0));
        if (q.size() != 0)
            chk("msg_data", 32'(bus.msg_data), 32'(q[0]));
    endtask

    task automatic model_write(input logic [31:0] addr,
                               input logic [31:0] data,
                               input logic [2:0] size);
        logic [7:0] b;
        if (size > 3'd2) return;
        case (addr[3:2])
            2'd0: if (data >= 1 && data <= 4)
                      m_start[data[1:0] - 2'd1] = 1'b1;
            2'd1: m_start = m_start & ~data[3:0];
            2'd2: begin
                if (size == 3'd0)
                    b = 8'(data >> (8 * int'(addr[1:0])));
                else if (size == 3'd1)
                    b = addr[1] ? data[23:16] : data[7:0];
                else
                    b = data[7:0];
                if (q.size() < DEPTH) q.push_back(b);
                else if (m_ovf < 255) m_ovf++;
            end
            default: begin
                m_done = 1'b1;
                m_code = data[7:0];
            end
        endcase
    endtask

    // One clock: pop happens before the same-edge push in the model
    task automatic cyc();
        bit popping;
        if (rand_rdy) bus.msg_ready = 1'($urandom_range(0, 1));
        popping = bus.msg_ready && q.size() > 0;
        @(posedge hclk);
        if (!hresetn) model_reset();
        else begin
            if (popping) q.delete(0);
            if (c_en) model_write(c_addr, c_data, c_size);
        end
        @(negedge hclk);
        check_all();
    endtask

    task automatic idle(input int n);
        bus.hsel = 1'b0;
        bus.htrans = 2'b00;
        bus.hwrite = 1'b0;
        bus.hreadyi = 1'b1;
        repeat (n) cyc();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [2:0] size, input int nwait,
                      input bit sel, input bit rdy_commit);
        bit hit;
        bus.hsel = sel;
        bus.haddr = addr;
        bus.htrans = 2'b10;
        bus.hwrite = 1'b1;
        bus.hsize = size;
        bus.hreadyi = 1'b1;
        hit = sel && (addr[19:4] == BASE[19:4]);
        cyc();
        bus.hsel = 1'b0;
        bus.htrans = 2'b00;
        bus.hwrite = 1'b0;
        bus.haddr = $urandom;
        for (int w = 0; w < nwait; w++) begin
            bus.hreadyi = 1'b0;
            bus.hwdata = $urandom;
            cyc();
        end
        bus.hreadyi = 1'b1;
        bus.hwdata = data;
        c_en = hit;
        c_addr = addr;
        c_data = data;
        c_size = size;
        if (rdy_commit) bus.msg_ready = 1'b1;
        cyc();
        c_en = 1'b0;
        if (rdy_commit) bus.msg_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] a, d;
        logic [2:0]  s;
        int          r;

        vecs = 0;
        errs = 0;
        c_en = 1'b0;
        c_addr = '0;
        c_data = '0;
        c_size = '0;
        rand_rdy = 1'b0;
        bus.haddr = '0;
        bus.htrans = 2'b00;
        bus.hwrite = 1'b0;
        bus.hsize = 3'd0;
        bus.hwdata = '0;
        bus.hreadyi = 1'b1;
        bus.hsel = 1'b0;
        bus.msg_ready = 1'b0;
        model_reset();

        tbl[0]  = '{BASE,         32'd2,  3'd2, 1'b1, 4'b0010, 1'b0, 8'h00};
        tbl[1]  = '{BASE,         32'd0,  3'd2, 1'b1, 4'b0010, 1'b0, 8'h00};
        tbl[2]  = '{BASE,         32'd7,  3'd2, 1'b1, 4'b0010, 1'b0, 8'h00};
        tbl[3]  = '{BASE,         32'd1,  3'd2, 1'b1, 4'b0011, 1'b0, 8'h00};
        tbl[4]  = '{BASE,         32'd3,  3'd2, 1'b1, 4'b0111, 1'b0, 8'h00};
        tbl[5]  = '{BASE,         32'd4,  3'd2, 1'b1, 4'b1111, 1'b0, 8'h00};
        tbl[6]  = '{BASE + 32'h4, 32'h5,  3'd2, 1'b1, 4'b1010, 1'b0, 8'h00};
        tbl[7]  = '{BASE,         32'd3,  3'd2, 1'b1, 4'b1110, 1'b0, 8'h00};
        tbl[8]  = '{BASE + 32'h4, 32'h4,  3'd2, 1'b1, 4'b1010, 1'b0, 8'h00};
        tbl[9]  = '{BASE + 32'hC, 32'hA5, 3'd2, 1'b1, 4'b1010, 1'b1, 8'hA5};
        tbl[10] = '{BASE + 32'h10, 32'd1, 3'd2, 1'b1, 4'b1010, 1'b1, 8'hA5};
        tbl[11] = '{BASE + 32'hC, 32'h11, 3'd3, 1'b1, 4'b1010, 1'b1, 8'hA5};
        tbl[12] = '{BASE + 32'hC, 32'h3C, 3'd2, 1'b1, 4'b1010, 1'b1, 8'h3C};
        tbl[13] = '{BASE,         32'd1,  3'd2, 1'b0, 4'b1010, 1'b1, 8'h3C};

        repeat (2) @(negedge hclk);
        chk("reset test_start", 32'(test_start), 0);
        chk("reset test_done", 32'(test_done), 0);
        chk("reset fifo_level", 32'(fifo_level), 0);
        chk("reset msg_valid", 32'(bus.msg_valid), 0);
        hresetn = 1'b1;
        idle(1);

        foreach (tbl[i]) begin
            wr(tbl[i].addr, tbl[i].data, tbl[i].size, 0, tbl[i].sel, 0);
            chk($sformatf("tbl%0d start", i), 32'(test_start), 32'(tbl[i].es));
            chk($sformatf("tbl%0d done", i), 32'(test_done), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d code", i), 32'(test_code), 32'(tbl[i].ec));
        end

        wr(BASE + 32'h8, 32'h0000_0048, 3'd0, 0, 1'b1, 1'b0);
        wr(BASE + 32'h9, 32'h0000_6900, 3'd0, 0, 1'b1, 1'b0);
        chk("hi level", 32'(fifo_level), 2);
        chk("hi head H", 32'(bus.msg_data), 32'h48);
        bus.msg_ready = 1'b1;
        cyc();
        chk("hi head i", 32'(bus.msg_data), 32'h69);
        cyc();
        chk("hi empty", 32'(bus.msg_valid), 0);
        bus.msg_ready = 1'b0;

        for (int i = 0; i < 18; i++)
            wr(BASE + 32'h8, $urandom, 3'd2, 0, 1'b1, 1'b0);
        chk("full level", 32'(fifo_level), 16);
        chk("full ovf", 32'(ovf_cnt), 2);
        wr(BASE + 32'h8, 32'h5A, 3'd2, 0, 1'b1, 1'b1);
        chk("full pushpop level", 32'(fifo_level), 16);
        chk("full pushpop ovf", 32'(ovf_cnt), 2);
        bus.msg_ready = 1'b1;
        idle(17);
        bus.msg_ready = 1'b0;

        wr(BASE + 32'h8, 32'h77, 3'd0, 3, 1'b1, 1'b0);
        chk("wait level", 32'(fifo_level), 1);
        chk("wait data", 32'(bus.msg_data), 32'h77);

        // Back-to-back: second address phase in the first commit cycle
        bus.hsel = 1'b1;
        bus.htrans = 2'b10;
        bus.hwrite = 1'b1;
        bus.hsize = 3'd0;
        bus.haddr = BASE + 32'h8;
        cyc();
        bus.haddr = BASE + 32'hA;
        bus.hwdata = 32'h0000_0041;
        c_en = 1'b1;
        c_addr = BASE + 32'h8;
        c_data = 32'h0000_0041;
        c_size = 3'd0;
        cyc();
        bus.hsel = 1'b0;
        bus.htrans = 2'b00;
        bus.hwdata = 32'h0042_0000;
        c_addr = BASE + 32'hA;
        c_data = 32'h0042_0000;
        cyc();
        c_en = 1'b0;
        chk("b2b level", 32'(fifo_level), 3);

        bus.msg_ready = 1'b1;
        idle(4);
        bus.msg_ready = 1'b0;
        bus.hsel = 1'b1;
        bus.htrans = 2'b10;
        bus.hwrite = 1'b1;
        bus.hsize = 3'd2;
        bus.haddr = BASE + 32'h8;
        cyc();
        bus.hsel = 1'b0;
        bus.htrans = 2'b00;
        bus.hwrite = 1'b0;
        bus.hreadyi = 1'b0;
        bus.hwdata = 32'h33;
        cyc();
        cyc();
        hresetn = 1'b0;
        #1;
        chk("rst start", 32'(test_start), 0);
        chk("rst done", 32'(test_done), 0);
        chk("rst code", 32'(test_code), 0);
        chk("rst level", 32'(fifo_level), 0);
        chk("rst ovf", 32'(ovf_cnt), 0);
        chk("rst valid", 32'(bus.msg_valid), 0);
        model_reset();
        bus.hreadyi = 1'b1;
        cyc();
        hresetn = 1'b1;
        cyc();
        chk("rst no push", 32'(fifo_level), 0);

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            a = BASE | 32'($urandom_range(0, 15));
            if (r == 9) a = BASE + 32'h10 + 32'($urandom_range(0, 15));
            else if (r < 4) a = (a & ~32'hC) | 32'h8;
            s = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                            : 3'($urandom_range(0, 2));
            case (a[3:2])
                2'd0: d = 32'($urandom_range(0, 6));
                2'd1: d = 32'($urandom_range(0, 15));
                default: d = $urandom;
            endcase
            wr(a, d, s, $urandom_range(0, 2),
               $urandom_range(0, 7) != 0, 1'b0);
            idle($urandom_range(0, 1));
        end
        rand_rdy = 1'b0;
        bus.msg_ready = 1'b1;
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
